// File: rtl/operand_collector_unit.sv
// One operand-collector unit: latches an issued instruction, requests up to four
// source operands from the bank arbiter, gathers the returned data and dispatches it.
module operand_collector_unit #(
  parameter int NUM_BANK      = 4,
  parameter int DEPTH_BANK    = 2,
  parameter int WID_W         = 3,
  parameter int REG_IDX_W     = 5,
  parameter int DEPTH_REGBANK = WID_W + REG_IDX_W - DEPTH_BANK,
  parameter int DATA_W        = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WID_W-1:0]           in_wid,
  input  logic [4*REG_IDX_W-1:0]     in_rs_idx,
  input  logic [7:0]                 in_rs_type,
  input  logic [DATA_W-1:0]          in_imm,
  output logic [3:0]                 arb_valid_o,
  output logic [4*DEPTH_BANK-1:0]    arb_bankID_o,
  output logic [7:0]                 arb_rsType_o,
  output logic [4*DEPTH_REGBANK-1:0] arb_rsAddr_o,
  input  logic [3:0]                 arb_grant_i,
  input  logic [3:0]                 rd_valid_i,
  input  logic [4*DATA_W-1:0]        rd_data_i,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WID_W-1:0]           out_wid,
  output logic [4*DATA_W-1:0]        out_data
);

  typedef enum logic [1:0] {
    CU_EMPTY    = 2'd0,
    CU_COLLECT  = 2'd1,
    CU_DISPATCH = 2'd2
  } cu_state_t;

  typedef enum logic [1:0] {
    OP_IDLE = 2'd0,
    OP_REQ  = 2'd1,
    OP_WAIT = 2'd2,
    OP_DONE = 2'd3
  } op_state_t;

  localparam logic [1:0] TYPE_IMM = 2'b11;

  // Registers are interleaved across banks by warp id so warps spread their traffic.
  function automatic logic [DEPTH_BANK-1:0] bank_of(
    input logic [DEPTH_BANK-1:0] idx_lo,
    input logic [DEPTH_BANK-1:0] wid_lo
  );
    return idx_lo + wid_lo;
  endfunction

  cu_state_t                cu_state_r;
  op_state_t                op_state_r [4];
  logic [WID_W-1:0]         wid_r;
  logic [DEPTH_BANK-1:0]    bank_r     [4];
  logic [DEPTH_REGBANK-1:0] addr_r     [4];
  logic [7:0]               type_r;
  logic [DATA_W-1:0]        imm_r;
  logic [DATA_W-1:0]        data_r     [4];

  logic in_ready_s;
  logic alloc_s;
  logic all_done_s;

  // Handshake decode and completion detect.
  always_comb begin
    in_ready_s = (cu_state_r == CU_EMPTY) ||
                 ((cu_state_r == CU_DISPATCH) && out_ready);
    alloc_s    = in_valid && in_ready_s;
    all_done_s = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (op_state_r[k] != OP_DONE) begin
        all_done_s = 1'b0;
      end else begin
        all_done_s = all_done_s;
      end
    end
  end

  // CU and per-operand state machines, request fields and operand data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cu_state_r <= CU_EMPTY;
      wid_r      <= '0;
      type_r     <= 8'h00;
      imm_r      <= '0;
      for (int k = 0; k < 4; k++) begin
        op_state_r[k] <= OP_IDLE;
        bank_r[k]     <= '0;
        addr_r[k]     <= '0;
        data_r[k]     <= '0;
      end
    end else if (alloc_s) begin
      // Operands sit in IDLE for one cycle while the registered address fields settle.
      cu_state_r <= CU_COLLECT;
      wid_r      <= in_wid;
      type_r     <= in_rs_type;
      imm_r      <= in_imm;
      for (int k = 0; k < 4; k++) begin
        op_state_r[k] <= OP_IDLE;
        bank_r[k]     <= bank_of(in_rs_idx[k*REG_IDX_W +: DEPTH_BANK],
                                 in_wid[DEPTH_BANK-1:0]);
        addr_r[k]     <= {in_wid, in_rs_idx[k*REG_IDX_W+DEPTH_BANK +: REG_IDX_W-DEPTH_BANK]};
        data_r[k]     <= '0;
      end
    end else begin
      case (cu_state_r)
        CU_EMPTY: begin
          cu_state_r <= CU_EMPTY;
        end
        CU_COLLECT: begin
          if (all_done_s) begin
            cu_state_r <= CU_DISPATCH;
          end else begin
            cu_state_r <= CU_COLLECT;
          end
          for (int k = 0; k < 4; k++) begin
            case (op_state_r[k])
              OP_IDLE: begin
                if (type_r[2*k +: 2] == TYPE_IMM) begin
                  op_state_r[k] <= OP_DONE;
                  data_r[k]     <= imm_r;
                end else begin
                  op_state_r[k] <= OP_REQ;
                end
              end
              OP_REQ: begin
                if (arb_grant_i[k]) begin
                  op_state_r[k] <= OP_WAIT;
                end else begin
                  op_state_r[k] <= OP_REQ;
                end
              end
              OP_WAIT: begin
                if (rd_valid_i[k]) begin
                  op_state_r[k] <= OP_DONE;
                  data_r[k]     <= rd_data_i[k*DATA_W +: DATA_W];
                end else begin
                  op_state_r[k] <= OP_WAIT;
                end
              end
              OP_DONE: begin
                op_state_r[k] <= OP_DONE;
              end
              default: begin
                op_state_r[k] <= OP_IDLE;
              end
            endcase
          end
        end
        CU_DISPATCH: begin
          if (out_ready) begin
            cu_state_r <= CU_EMPTY;
            for (int k = 0; k < 4; k++) begin
              op_state_r[k] <= OP_IDLE;
            end
          end else begin
            cu_state_r <= CU_DISPATCH;
          end
        end
        default: begin
          cu_state_r <= CU_EMPTY;
        end
      endcase
    end
  end

  // Output packing from registered state only; no path from the grant inputs.
  always_comb begin
    in_ready     = in_ready_s;
    out_valid    = (cu_state_r == CU_DISPATCH);
    out_wid      = wid_r;
    arb_rsType_o = type_r;
    arb_valid_o  = 4'b0000;
    arb_bankID_o = '0;
    arb_rsAddr_o = '0;
    out_data     = '0;
    for (int k = 0; k < 4; k++) begin
      arb_valid_o[k]                             = (op_state_r[k] == OP_REQ);
      arb_bankID_o[k*DEPTH_BANK +: DEPTH_BANK]   = bank_r[k];
      arb_rsAddr_o[k*DEPTH_REGBANK +: DEPTH_REGBANK] = addr_r[k];
      out_data[k*DATA_W +: DATA_W]               = data_r[k];
    end
  end

endmodule

// File: tb/tb_operand_collector_unit.sv
// Directed self-checking bench for operand_collector_unit: reset, address mapping,
// latency, delayed grants, immediates, stalls, back-to-back issue and spurious inputs.
module tb_operand_collector_unit;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   in_wid;
  logic [19:0]  in_rs_idx;
  logic [7:0]   in_rs_type;
  logic [31:0]  in_imm;
  logic [3:0]   arb_valid_o;
  logic [7:0]   arb_bankID_o;
  logic [7:0]   arb_rsType_o;
  logic [23:0]  arb_rsAddr_o;
  logic [3:0]   arb_grant_i;
  logic [3:0]   rd_valid_i;
  logic [127:0] rd_data_i;
  logic         out_valid;
  logic         out_ready;
  logic [2:0]   out_wid;
  logic [127:0] out_data;

  int total = 0;
  int bad   = 0;

  operand_collector_unit dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_wid       (in_wid),
    .in_rs_idx    (in_rs_idx),
    .in_rs_type   (in_rs_type),
    .in_imm       (in_imm),
    .arb_valid_o  (arb_valid_o),
    .arb_bankID_o (arb_bankID_o),
    .arb_rsType_o (arb_rsType_o),
    .arb_rsAddr_o (arb_rsAddr_o),
    .arb_grant_i  (arb_grant_i),
    .rd_valid_i   (rd_valid_i),
    .rd_data_i    (rd_data_i),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_wid      (out_wid),
    .out_data     (out_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_wid = 3'd0; in_rs_idx = 20'd0; in_rs_type = 8'h00;
    in_imm = 32'd0; arb_grant_i = 4'h0; rd_valid_i = 4'h0; rd_data_i = 128'd0; out_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    total++; if (arb_valid_o !== 4'h0) begin bad++; $display("FAIL reset_arb_valid got=%h exp=0", arb_valid_o); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    total++; if (out_data !== 128'd0 || out_wid !== 3'd0) begin bad++; $display("FAIL reset_out got=%h/%h exp=0/0", out_data, out_wid); end
  endtask

  task automatic test_spurious();
    arb_grant_i = 4'hF; rd_valid_i = 4'hF; rd_data_i = {4{32'hDEADBEEF}};
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (out_data !== 128'd0 || out_valid !== 1'b0 || arb_valid_o !== 4'h0 || in_ready !== 1'b1) begin
        bad++; $display("FAIL spurious got data=%h ov=%b av=%h ir=%b exp 0/0/0/1", out_data, out_valid, arb_valid_o, in_ready);
      end
    end
    arb_grant_i = 4'h0; rd_valid_i = 4'h0; rd_data_i = 128'd0;
  endtask

  task automatic test_basic();
    logic [127:0] exp_data;
    exp_data = {32'h33333333, 32'h22222222, 32'h11111111, 32'h00000000};
    out_ready = 1'b1;
    in_valid = 1'b1; in_wid = 3'd3; in_rs_idx = {5'd7, 5'd6, 5'd5, 5'd4}; in_rs_type = 8'h55;
    tick();  // allocation edge
    in_valid = 1'b0;
    total++; if (arb_valid_o !== 4'h0 || in_ready !== 1'b0) begin bad++; $display("FAIL basic_alloc got av=%h ir=%b exp 0/0", arb_valid_o, in_ready); end
    total++; if (arb_bankID_o !== 8'h93) begin bad++; $display("FAIL basic_bank got=%h exp=93", arb_bankID_o); end
    total++; if (arb_rsAddr_o !== 24'h659659) begin bad++; $display("FAIL basic_addr got=%h exp=659659", arb_rsAddr_o); end
    total++; if (arb_rsType_o !== 8'h55) begin bad++; $display("FAIL basic_type got=%h exp=55", arb_rsType_o); end
    tick();
    total++; if (arb_valid_o !== 4'hF) begin bad++; $display("FAIL basic_req got=%h exp=f", arb_valid_o); end
    arb_grant_i = 4'hF;
    tick();
    total++; if (arb_valid_o !== 4'h0) begin bad++; $display("FAIL basic_req_drop got=%h exp=0", arb_valid_o); end
    arb_grant_i = 4'h0; rd_valid_i = 4'hF; rd_data_i = exp_data;
    tick();
    rd_valid_i = 4'h0; rd_data_i = 128'd0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_early_valid got=%b exp=0", out_valid); end
    tick();  // fourth edge after allocation
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL basic_out_valid got=%b exp=1", out_valid); end
    total++; if (out_data !== exp_data || out_wid !== 3'd3) begin bad++; $display("FAIL basic_out_data got=%h/%h exp=%h/3", out_data, out_wid, exp_data); end
    tick();
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL basic_handshake got ov=%b ir=%b exp 0/1", out_valid, in_ready); end
  endtask

  task automatic test_delayed_grant_stall_back_to_back();
    logic [127:0] exp_data;
    int held;
    exp_data = {32'hA0A0A003, 32'hB1B1B1B1, 32'hC2C2C2C2, 32'hD3D3D3D3};
    held = 0;
    out_ready = 1'b0;
    in_valid = 1'b1; in_wid = 3'd5; in_rs_idx = {5'd9, 5'd18, 5'd27, 5'd2}; in_rs_type = 8'h49;
    tick();
    in_valid = 1'b0;
    total++; if (arb_bankID_o !== 8'hB3 || arb_rsAddr_o !== 24'hAACBA8 || arb_rsType_o !== 8'h49) begin
      bad++; $display("FAIL delay_fields got=%h/%h/%h exp=b3/aacba8/49", arb_bankID_o, arb_rsAddr_o, arb_rsType_o);
    end
    tick();
    if (arb_valid_o[1]) held++;
    total++; if (arb_valid_o !== 4'hF) begin bad++; $display("FAIL delay_req got=%h exp=f", arb_valid_o); end
    arb_grant_i = 4'b1101;
    tick();
    if (arb_valid_o[1]) held++;
    total++; if (arb_valid_o !== 4'b0010) begin bad++; $display("FAIL delay_others_drop got=%h exp=2", arb_valid_o); end
    arb_grant_i = 4'h0; rd_valid_i = 4'b1101; rd_data_i = exp_data;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (arb_valid_o[1]) held++;
      rd_valid_i = 4'h0;
      if (i == 2) arb_grant_i = 4'b0010;
    end
    tick();
    arb_grant_i = 4'h0;
    total++; if (held != 5 || arb_valid_o !== 4'h0) begin bad++; $display("FAIL delay_held got=%0d/%h exp=5/0", held, arb_valid_o); end
    rd_valid_i = 4'b0010;
    tick();  // operand 1 reaches DONE
    rd_valid_i = 4'h0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL delay_early_valid got=%b exp=0", out_valid); end
    tick();
    total++; if (out_valid !== 1'b1 || out_data !== exp_data || out_wid !== 3'd5) begin
      bad++; $display("FAIL delay_out got=%b/%h/%h exp=1/%h/5", out_valid, out_data, out_wid, exp_data);
    end
    // downstream stall: contents must hold and nothing new may enter
    in_valid = 1'b1; in_wid = 3'd6; in_rs_idx = 20'd0; in_rs_type = 8'hFF; in_imm = 32'hA5A5A5A5;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== exp_data || out_wid !== 3'd5 || arb_bankID_o !== 8'hB3) begin
        bad++; $display("FAIL stall_hold cyc=%0d got=%b/%b/%h/%h exp=1/0/%h/5", i, out_valid, in_ready, out_data, out_wid, exp_data);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_in_ready got=%b exp=1", in_ready); end
    tick();  // handshake and allocation share this edge
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b0 || out_wid !== 3'd6 || in_ready !== 1'b0) begin
      bad++; $display("FAIL b2b_alloc got ov=%b wid=%h ir=%b exp 0/6/0", out_valid, out_wid, in_ready);
    end
    tick();
    total++; if (out_valid !== 1'b0 || arb_valid_o !== 4'h0) begin bad++; $display("FAIL imm_early got=%b/%h exp=0/0", out_valid, arb_valid_o); end
    tick();  // second edge after allocation
    total++; if (out_valid !== 1'b1 || out_data !== {4{32'hA5A5A5A5}} || arb_valid_o !== 4'h0) begin
      bad++; $display("FAIL imm_out got=%b/%h/%h exp=1/a5a5..a5/0", out_valid, out_data, arb_valid_o);
    end
    tick();
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL imm_release got=%b/%b exp=0/1", out_valid, in_ready); end
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b1; in_wid = 3'd1; in_rs_idx = {5'd3, 5'd2, 5'd1, 5'd0}; in_rs_type = 8'h55;
    tick();
    in_valid = 1'b0;
    tick();
    arb_grant_i = 4'hF;
    tick();
    arb_grant_i = 4'h0; rd_valid_i = 4'b1011; rd_data_i = {4{32'h12345678}};
    tick();  // operand 2 left in WAIT
    rd_valid_i = 4'h0;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin bad++; $display("FAIL mid_pre got=%b/%b exp=0/0", out_valid, in_ready); end
    rst = 1'b1;
    #1;
    total++; if (arb_valid_o !== 4'h0 || out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 128'd0 || out_wid !== 3'd0) begin
      bad++; $display("FAIL mid_reset got av=%h ov=%b ir=%b data=%h wid=%h exp 0/0/1/0/0", arb_valid_o, out_valid, in_ready, out_data, out_wid);
    end
    tick();
    rst = 1'b0;
    rd_valid_i = 4'b0100; rd_data_i = {4{32'hFFFFFFFF}};
    tick();
    rd_valid_i = 4'h0;
    tick();
    total++; if (out_data !== 128'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL mid_late_rd got data=%h ov=%b ir=%b exp 0/0/1", out_data, out_valid, in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_spurious();
    test_basic();
    test_delayed_grant_stall_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
